// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware output FIFO with header tags, read-side packet length tracking and write-side packet abort
//   clock, resetn (async active-low), soft_reset (sync flush)
//   write_enb, lfd_state (header tag), pkt_abort, data_in        -> write side
//   read_enb -> data_out, data_valid, pkt_last (1-cycle latency) -> read side
//   empty, full, almost_full, fill_level, abort_err              -> registered status
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 14
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      soft_reset,
    input  logic                      write_enb,
    input  logic                      lfd_state,
    input  logic                      pkt_abort,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      read_enb,
    output logic [DATA_W-1:0]         data_out,
    output logic                      data_valid,
    output logic                      pkt_last,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      abort_err
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   rd_word;
    logic [AW:0]       wr_ptr, rd_ptr, pkt_start, wr_nxt, rd_nxt, used, pkt_len, lvl_nxt;
    logic [DATA_W-2:0] cnt;
    logic              pkt_open, full_i, empty_i, wr_acc, rd_acc, abort_ok, abort_bad;

    assign empty_i   = wr_ptr == rd_ptr;
    assign full_i    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign used      = wr_ptr - rd_ptr;
    assign pkt_len   = wr_ptr - pkt_start;
    // the open packet is intact only while every one of its words is still stored
    assign abort_ok  = pkt_open && pkt_abort && used >= pkt_len;
    assign abort_bad = pkt_open && pkt_abort && used < pkt_len;
    assign wr_acc    = write_enb && !full_i && !abort_ok && !soft_reset;
    assign rd_acc    = read_enb && !empty_i;
    assign wr_nxt    = abort_ok ? pkt_start : wr_ptr + (AW+1)'(wr_acc);
    assign rd_nxt    = rd_ptr + (AW+1)'(rd_acc);
    assign lvl_nxt   = wr_nxt - rd_nxt;
    assign rd_word   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (wr_acc)
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pkt_start   <= '0;
            pkt_open    <= 1'b0;
            cnt         <= '0;
            fill_level  <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            pkt_last    <= 1'b0;
            abort_err   <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pkt_start   <= '0;
            pkt_open    <= 1'b0;
            cnt         <= '0;
            fill_level  <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            pkt_last    <= 1'b0;
            abort_err   <= 1'b0;
        end else begin
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            fill_level  <= lvl_nxt;
            empty       <= lvl_nxt == '0;
            full        <= lvl_nxt == (AW+1)'(DEPTH);
            almost_full <= lvl_nxt >= (AW+1)'(AFULL_TH);
            abort_err   <= abort_bad;
            data_valid  <= rd_acc;
            if (abort_ok)
                pkt_open <= 1'b0;
            else if (wr_acc && lfd_state) begin
                pkt_open  <= 1'b1;
                pkt_start <= wr_ptr;
            end
            if (rd_acc) begin
                data_out <= rd_word[DATA_W-1:0];
                // header length covers payload plus the trailing parity word
                cnt      <= rd_word[DATA_W] ? (DATA_W-1)'(rd_word[DATA_W-1:2]) + (DATA_W-1)'(1)
                          : (cnt != '0) ? cnt - (DATA_W-1)'(1) : cnt;
                pkt_last <= !rd_word[DATA_W] && cnt == (DATA_W-1)'(1);
            end else
                pkt_last <= 1'b0;
        end
    end
endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware FIFO. It is the next-generation output buffer between the router write path and each destination port.
- Each stored word carries a header tag. A read-side down-counter tracks packet length from the header, and an end-of-packet strobe marks the last word read.
- New over the fixed 8x16 buffer: parametrised width and depth, write-side packet abort with pointer rollback, registered occupancy and almost-full outputs, and a valid strobe instead of tri-stated output.

Parameters:
- DATA_W, 8: data word width in bits. Must be >= 4.
- DEPTH, 16: number of words. Must be a power of 2, >= 4.
- AFULL_TH, 14: almost_full asserts when fill_level >= AFULL_TH. Range 1..DEPTH.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- soft_reset  in  1  synchronous flush, active-high.
- write_enb  in  1  write request.
- lfd_state  in  1  the word written this cycle is a packet header.
- pkt_abort  in  1  discard the partially written current packet.
- data_in  in  DATA_W  write data.
- read_enb  in  1  read request.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out holds a word read last cycle.
- pkt_last  out  1  data_out is the final word (parity) of a packet.
- empty  out  1  no words stored.
- full  out  1  DEPTH words stored.
- almost_full  out  1  fill_level >= AFULL_TH.
- fill_level  out  clog2(DEPTH)+1  stored word count.
- abort_err  out  1  one-cycle pulse: abort refused.

Behaviour:
- Reset, asynchronous on resetn low:
  - Pointers, count, fill_level, data_out, data_valid, pkt_last, abort_err and the open-packet flag all go to 0.
  - empty=1, full=0, almost_full=0.
  - Memory contents are not cleared.
- soft_reset, synchronous: same effect as reset; it has priority over every other input.
- Storage: memory is DEPTH x (DATA_W+1). Bit DATA_W is the header tag, equal to lfd_state in the write cycle.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - empty when the pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
- Write: accepted when write_enb && !full. A write while full is dropped with no state change.
- Read: accepted when read_enb && !empty. A read while empty is ignored.
  - Read latency is 1 cycle: data_out and data_valid update on the edge after acceptance.
  - data_valid=0 in any cycle with no accepted read; data_out then holds its last value. It is never driven to Z.
- Simultaneous read and write are allowed in every state, including full and empty.
  - When full, only the read is accepted that cycle.
  - When empty, only the write is accepted that cycle; there is no fall-through.
- fill_level, almost_full, empty and full reflect pointer state after the edge.
- Packet counter (read side), cnt of DATA_W-1 bits:
  - Header read: cnt <= header[DATA_W-1:2] + 1, covering payload plus parity.
  - Non-header read with cnt != 0: cnt decrements.
  - Non-header read with cnt==1: pkt_last=1 alongside that word.
  - A payload length of 0 gives cnt=1, so the next word is flagged last.
- Packet open flag (write side):
  - An accepted header write sets open=1 and captures pkt_start = wr_ptr.
  - A header write while already open re-captures pkt_start; the prior packet is treated as complete.
- pkt_abort while open=1:
  - Honoured if no word of the open packet has been read, i.e. (wr_ptr - rd_ptr) >= (wr_ptr - pkt_start). Then wr_ptr <= pkt_start and open <= 0.
  - Otherwise it is ignored and abort_err pulses for 1 cycle.
- pkt_abort with open=0: no effect, no error.
- Abort wins over a same-cycle write; that write is dropped.
- A same-cycle read of an older packet proceeds normally.

Test Plan:
- DATA_W=8, DEPTH=16: reset, then write header 0x0C (length 3) plus 4 words, then read 5 -> data_valid on each read; pkt_last only on the 5th; empty=1 after.
- Write 16 words -> full=1, fill_level=16, almost_full=1 from the 14th word. A 17th write is dropped. Simultaneous read+write while full -> fill_level=15.
- Pointer wrap: 40 words streamed with alternating single reads and writes -> data order preserved; empty toggles correctly across the index wrap.
- Header 0x10 plus 2 payload words written, then pkt_abort -> fill_level returns to its pre-header value. Next packet overwrites the same slots and reads back intact.
- Open packet with its header already read, then pkt_abort -> abort_err=1 for 1 cycle; wr_ptr unchanged.
- Asynchronous resetn pulse mid-packet (between clock edges) -> outputs clear immediately. soft_reset mid-read -> data_valid=0 and fill_level=0 next cycle.
